// File: rtl/hier_node_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : hier_node_seq_if
// Purpose  : Bundles the parent handshake and child channel signals of one
//            hierarchy-tree node so a level of the tree connects with a
//            single port.
// Modports : slave  - the node controller (hier_node_seq)
//            master - the parent plus the child completion sources
// Signals  : start_i       parent start request (1-cycle)
//            child_en_i    per-child enable, latched on accepted start
//            child_start_o per-child launch pulse
//            child_done_i  per-child completion (pulse or level)
//            busy_o        node is working on a start
//            done_o        1-cycle completion pulse to the parent
//            active_idx_o  child awaited in sequential mode, else 0
//            err_o         sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
interface hier_node_seq_if #(
    parameter int NUM_CHILDREN = 15,
    parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
);
    logic                    start_i;
    logic [NUM_CHILDREN-1:0] child_en_i;
    logic [NUM_CHILDREN-1:0] child_start_o;
    logic [NUM_CHILDREN-1:0] child_done_i;
    logic                    busy_o;
    logic                    done_o;
    logic [IDX_W-1:0]        active_idx_o;
    logic                    err_o;

    modport slave (
        input  start_i,
        input  child_en_i,
        input  child_done_i,
        output child_start_o,
        output busy_o,
        output done_o,
        output active_idx_o,
        output err_o
    );

    modport master (
        output start_i,
        output child_en_i,
        output child_done_i,
        input  child_start_o,
        input  busy_o,
        input  done_o,
        input  active_idx_o,
        input  err_o
    );
endinterface
`default_nettype wire

// File: rtl/hier_node_seq.sv
`default_nettype none
// ============================================================================
// Module   : hier_node_seq
// Purpose  : Parametrised hierarchy-tree node controller. Accepts a start
//            token from its parent, launches the enabled children either one
//            at a time in index order (SEQUENTIAL=1) or all together
//            (SEQUENTIAL=0), collects their completions and returns a single
//            done pulse upward.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset, synchronous release
//            bus   - hier_node_seq_if.slave (start/enable/done handshakes,
//                    busy, active index, error flag)
// Options  : HIER_NODE_TIMEOUT_EN - when defined, each launch is bounded by
//            TIMEOUT_CYCLES wait cycles; on expiry err_o sets and the node
//            completes normally, abandoning unseen children. When undefined
//            WAIT is unbounded and err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module hier_node_seq #(
    parameter int NUM_CHILDREN   = 15,
    parameter int IDX_W          = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1,
    parameter bit SEQUENTIAL     = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    hier_node_seq_if.slave bus
);

    if (NUM_CHILDREN < 1 || NUM_CHILDREN > 64 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("hier_node_seq: NUM_CHILDREN or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CHILDREN-1:0] mask_q, mask_d;
    logic [NUM_CHILDREN-1:0] seen_q, seen_d;
    logic [NUM_CHILDREN-1:0] child_start_q, child_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        active_idx_q, active_idx_d;

    logic [NUM_CHILDREN-1:0] w_pending;
    logic [IDX_W-1:0]        w_next_idx;

`ifdef HIER_NODE_TIMEOUT_EN
    logic [31:0]             wait_cnt_q, wait_cnt_d;
    logic                    err_q, err_d;
`endif

    // Lowest-index enabled child that has not completed yet. Scanning from the
    // top down lets the last hit (the lowest index) win.
    always_comb begin
        w_pending  = mask_q & ~seen_q;
        w_next_idx = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_next_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        seen_d        = seen_q;
        child_start_d = '0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        active_idx_d  = active_idx_q;
`ifdef HIER_NODE_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    mask_d       = bus.child_en_i;
                    seen_d       = '0;
                    busy_d       = 1'b1;
                    active_idx_d = '0;
`ifdef HIER_NODE_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                    // An empty enable set has nothing to launch.
                    state_d      = (|bus.child_en_i) ? S_LAUNCH : S_DONE;
                end
            end

            S_LAUNCH: begin
`ifdef HIER_NODE_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                if (SEQUENTIAL) begin
                    child_start_d[w_next_idx] = 1'b1;
                    active_idx_d              = w_next_idx;
                end else begin
                    child_start_d = mask_q;
                end
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Completions of unmasked children never reach the seen vector;
                // a done coincident with its launch pulse is captured here too.
                seen_d = seen_q | (bus.child_done_i & mask_q);
                if (SEQUENTIAL) begin
                    if (seen_d[active_idx_q]) begin
                        state_d = (|(mask_q & ~seen_d)) ? S_LAUNCH : S_DONE;
                    end
                end else if ((seen_d & mask_q) == mask_q) begin
                    state_d = S_DONE;
                end
`ifdef HIER_NODE_TIMEOUT_EN
                if (state_d == S_WAIT) begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    if (wait_cnt_d == 32'(TIMEOUT_CYCLES)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
`endif
                if (state_d == S_DONE) begin
                    active_idx_d = '0;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            seen_q        <= '0;
            child_start_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            active_idx_q  <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            seen_q        <= seen_d;
            child_start_q <= child_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            active_idx_q  <= active_idx_d;
        end
    end

`ifdef HIER_NODE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    // All outputs come straight from registers, so they are glitch-free and
    // drop to zero as soon as reset asserts.
    assign bus.child_start_o = child_start_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.active_idx_o  = active_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_hier_node_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hier_node_seq
// Purpose  : Self-checking bench for hier_node_seq. A sequential node with 15
//            children and a parallel node with 4 children are driven with
//            randomized enables, child response delays and noise. Expected
//            launch times, done and busy windows are computed up front from
//            the node's timing rules and compared cycle by cycle.
// Options  : HIER_NODE_TIMEOUT_EN - adds the timeout scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hier_node_seq;

    localparam int TIMEOUT = 16;

    typedef struct {
        int          cyc;
        logic [63:0] vec;
        int          idx;
    } launch_t;

    logic clk;
    logic rst_n;

    hier_node_seq_if #(.NUM_CHILDREN(15)) seq_if ();
    hier_node_seq_if #(.NUM_CHILDREN(4))  par_if ();

    hier_node_seq #(
        .NUM_CHILDREN  (15),
        .SEQUENTIAL    (1'b1),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) u_seq (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (seq_if.slave)
    );

    hier_node_seq #(
        .NUM_CHILDREN  (4),
        .SEQUENTIAL    (1'b0),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) u_par (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (par_if.slave)
    );

    // Bench-side stimulus, shared by both nodes; sel_par routes start and
    // picks which node's outputs are observed.
    logic        sel_par;
    logic        start_b;
    logic [63:0] en_b;
    logic [63:0] done_b;

    assign seq_if.start_i      = start_b & ~sel_par;
    assign seq_if.child_en_i   = en_b[14:0];
    assign seq_if.child_done_i = done_b[14:0];
    assign par_if.start_i      = start_b & sel_par;
    assign par_if.child_en_i   = en_b[3:0];
    assign par_if.child_done_i = done_b[3:0];

    logic [63:0] cs_w, busy_w, done_w, err_w, idx_w;
    assign cs_w   = sel_par ? 64'(par_if.child_start_o) : 64'(seq_if.child_start_o);
    assign busy_w = sel_par ? 64'(par_if.busy_o)        : 64'(seq_if.busy_o);
    assign done_w = sel_par ? 64'(par_if.done_o)        : 64'(seq_if.done_o);
    assign err_w  = sel_par ? 64'(par_if.err_o)         : 64'(seq_if.err_o);
    assign idx_w  = sel_par ? 64'(par_if.active_idx_o)  : 64'(seq_if.active_idx_o);

    int      n_total = 0;
    int      n_bad   = 0;
    bit      exp_err = 1'b0;
    int      dly_tab[64];
    launch_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One start/complete transaction. Cycle 0 is the cycle start_i is driven;
    // abort_at >= 0 pulses reset in that cycle instead of letting it finish.
    task automatic run_case(input bit par, input logic [63:0] en, input bit level,
                            input int abort_at);
        int          n_ch, done_at, err_at, t, last, mx;
        bit          stuck;
        logic [63:0] cmask, en_m, exp_cs, db;
        launch_t     e;
        int          due[64];

        sel_par = par;
        #1;
        n_ch  = par ? 4 : 15;
        cmask = (64'd1 << n_ch) - 64'd1;
        en_m  = en & cmask;

        // Reference schedule from the timing rules.
        exp_q.delete();
        err_at  = -1;
        done_at = -1;
        if (en_m == 64'd0) begin
            done_at = 2;
        end else if (!par) begin
            t    = 2;
            last = 0;
            for (int i = 0; i < n_ch; i++) begin
                if (en_m[i]) begin
                    e.cyc = t;
                    e.vec = 64'd1 << i;
                    e.idx = i;
                    exp_q.push_back(e);
                    if (dly_tab[i] < 0) begin
                        err_at  = t + TIMEOUT;
                        done_at = t + TIMEOUT + 1;
                        break;
                    end
                    last = t + dly_tab[i];
                    t    = last + 2;
                end
            end
            if (done_at < 0) done_at = last + 2;
        end else begin
            e.cyc = 2;
            e.vec = en_m;
            e.idx = 0;
            exp_q.push_back(e);
            mx    = 0;
            stuck = 1'b0;
            for (int i = 0; i < n_ch; i++) begin
                if (en_m[i]) begin
                    if (dly_tab[i] < 0) stuck = 1'b1;
                    else if (dly_tab[i] > mx) mx = dly_tab[i];
                end
            end
            if (stuck) begin
                err_at  = 2 + TIMEOUT;
                done_at = 2 + TIMEOUT + 1;
            end else begin
                done_at = 2 + mx + 2;
            end
        end

        for (int i = 0; i < 64; i++) due[i] = -1;

        for (int n = 0; n <= done_at + 2; n++) begin
            exp_cs = 64'd0;
            if (exp_q.size() > 0 && exp_q[0].cyc == n) begin
                e      = exp_q.pop_front();
                exp_cs = e.vec;
                if (!par) check("active_idx", idx_w, 64'(e.idx));
            end
            if (n == 1) exp_err = 1'b0;
            if (n == err_at) exp_err = 1'b1;
            check("child_start", cs_w, exp_cs);
            check("done", done_w, 64'(n == done_at));
            check("busy", busy_w, 64'(n >= 1 && n < done_at));
            check("err", err_w, 64'(exp_err));
            if (par) check("idx_par", idx_w, 64'd0);

            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_child_start", cs_w, 64'd0);
                check("rst_busy", busy_w, 64'd0);
                check("rst_done", done_w, 64'd0);
                check("rst_err", err_w, 64'd0);
                check("rst_idx", idx_w, 64'd0);
                start_b = 1'b0;
                done_b  = 64'd0;
                exp_err = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("post_rst_done", done_w, 64'd0);
                    check("post_rst_busy", busy_w, 64'd0);
                end
                return;
            end

            // Child behaviour: respond dly cycles after the observed launch.
            for (int i = 0; i < n_ch; i++) begin
                if (cs_w[i] && dly_tab[i] >= 0) due[i] = n + dly_tab[i];
            end
            db = {$urandom, $urandom} & {$urandom, $urandom} & ~en_m & cmask;
            for (int i = 0; i < n_ch; i++) begin
                if (due[i] >= 0 && (level ? (n >= due[i]) : (n == due[i]))) db[i] = 1'b1;
            end
            // Spurious starts while the node is busy must be ignored.
            start_b = (n == 0) || (n >= 1 && n <= done_at - 1 && $urandom_range(0, 7) == 0);
            en_b    = (n == 0) ? en : {$urandom, $urandom};
            done_b  = db;
            @(negedge clk);
        end
        start_b = 1'b0;
        done_b  = 64'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        sel_par = 1'b0;
        start_b = 1'b0;
        en_b    = 64'd0;
        done_b  = 64'd0;
        for (int i = 0; i < 64; i++) dly_tab[i] = 3;

        repeat (3) @(negedge clk);
        check("reset_seq_child_start", 64'(seq_if.child_start_o), 64'd0);
        check("reset_seq_busy", 64'(seq_if.busy_o), 64'd0);
        check("reset_seq_done", 64'(seq_if.done_o), 64'd0);
        check("reset_seq_idx", 64'(seq_if.active_idx_o), 64'd0);
        check("reset_seq_err", 64'(seq_if.err_o), 64'd0);
        check("reset_par_child_start", 64'(par_if.child_start_o), 64'd0);
        check("reset_par_busy", 64'(par_if.busy_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All 15 children, each done 3 cycles after its launch.
        run_case(1'b0, 64'h7FFF, 1'b0, -1);

        // Sparse enable: only children 0 and 2.
        for (int i = 0; i < 64; i++) dly_tab[i] = $urandom_range(0, 6);
        run_case(1'b0, 64'h0005, 1'b0, -1);

        // Parallel with dones at 4/9/2/7 cycles after launch.
        dly_tab[0] = 4; dly_tab[1] = 9; dly_tab[2] = 2; dly_tab[3] = 7;
        run_case(1'b1, 64'hF, 1'b0, -1);

        // Empty enable on both node styles.
        run_case(1'b0, 64'h0, 1'b0, -1);
        run_case(1'b1, 64'h0, 1'b0, -1);

        // Level-style completions, including a done coincident with launch.
        for (int i = 0; i < 64; i++) dly_tab[i] = i % 3;
        run_case(1'b0, 64'h5A3C, 1'b1, -1);

`ifdef HIER_NODE_TIMEOUT_EN
        // Child 1 never completes; child 2 is abandoned.
        dly_tab[0] = 2; dly_tab[1] = -1; dly_tab[2] = 3;
        run_case(1'b0, 64'h0007, 1'b0, -1);
        dly_tab[1] = 1;
        run_case(1'b0, 64'h0003, 1'b0, -1);
        dly_tab[1] = -1;
        run_case(1'b1, 64'hF, 1'b0, -1);
        dly_tab[1] = 2;
        run_case(1'b1, 64'hF, 1'b0, -1);
`endif

        // Reset pulsed in the middle of a parallel WAIT, then a fresh start.
        dly_tab[0] = 8; dly_tab[1] = 9; dly_tab[2] = 7; dly_tab[3] = 10;
        run_case(1'b1, 64'hF, 1'b0, 5);
        run_case(1'b1, 64'hF, 1'b0, -1);

        // Randomized transactions.
        for (int r = 0; r < 24; r++) begin
            bit          p;
            logic [63:0] en;
            p  = 1'($urandom_range(0, 1));
            en = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) en = 64'd0;
            for (int i = 0; i < 64; i++) dly_tab[i] = $urandom_range(0, 10);
            run_case(p, en, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
